// File: rtl/adder_stim_gen.sv
// Operand generator and sum checker for bring-up of an adder: issues directed and
// LFSR operand pairs, compares returned sums against a latency-matched expected pipe.
`timescale 1ns/1ps
module adder_stim_gen #(
  parameter int unsigned     DW    = 9,
  parameter int unsigned     NUM_W = 16,
  parameter int unsigned     LAT   = 1,
  parameter logic [2*DW-1:0] SEED  = 18'h1A5A5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num_ops,
  input  logic             gap_en,
  output logic [DW-1:0]    data_in0,
  output logic [DW-1:0]    data_in1,
  output logic             in_valid,
  input  logic [DW:0]      data_out,
  input  logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [NUM_W-1:0] pass_cnt,
  output logic [NUM_W-1:0] err_cnt
);

  localparam int unsigned     LfsrW    = 2 * DW;
  localparam logic [LfsrW-1:0] SeedInit = (SEED == '0) ? LfsrW'(1) : SEED;
  localparam int unsigned     CntW     = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [NUM_W-1:0]   num_ops_q, num_ops_d;
  logic               gap_en_q, gap_en_d;
  logic [NUM_W-1:0]   op_idx_q, op_idx_d;
  logic               gap_skip_q, gap_skip_d;
  logic [CntW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [LfsrW-1:0]   lfsr_q, lfsr_d;
  logic [DW-1:0]      a_q, a_d, b_q, b_d;
  logic               vld_q, vld_d;
  logic [NUM_W-1:0]   pass_q, pass_d, err_q, err_d;
  logic               mismatch_q, mismatch_d;
  logic               done_q, done_d;
  logic               dl_vld_q [LAT];
  logic [DW:0]        dl_sum_q [LAT];

  logic               accept, issue, last_op, fb;
  logic               tail_vld, good, bad;
  logic [DW:0]        tail_sum, sum_in;

  // Taps x^18 + x^11 + 1
  assign fb       = lfsr_q[LfsrW-1] ^ lfsr_q[LfsrW-8];
  assign sum_in   = {1'b0, a_q} + {1'b0, b_q};
  assign tail_vld = dl_vld_q[LAT-1];
  assign tail_sum = dl_sum_q[LAT-1];
  assign good     = tail_vld && out_valid && (data_out == tail_sum);
  assign bad      = (tail_vld && !good) || (!tail_vld && out_valid);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    last_op = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (num_ops == '0) ? StDone : StSend;
        end
      end
      StSend: begin
        issue   = !(gap_en_q && gap_skip_q);
        last_op = issue && (op_idx_q == num_ops_q - NUM_W'(1));
        if (last_op) state_d = StDrain;
      end
      StDrain: begin
        if (drain_cnt_q == CntW'(LAT - 1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    num_ops_d   = accept ? num_ops : num_ops_q;
    gap_en_d    = accept ? gap_en : gap_en_q;
    op_idx_d    = accept ? '0 : (issue ? op_idx_q + NUM_W'(1) : op_idx_q);
    gap_skip_d  = accept ? 1'b0 : ((state_q == StSend) ? issue : gap_skip_q);
    drain_cnt_d = (state_q == StDrain) ? drain_cnt_q + CntW'(1) : '0;
    vld_d       = issue;
    a_d         = '0;
    b_d         = '0;
    lfsr_d      = lfsr_q;
    if (issue) begin
      if (op_idx_q == NUM_W'(1)) begin
        a_d = '1;
        b_d = '1;
      end else if (op_idx_q != '0) begin
        a_d    = lfsr_q[DW-1:0];
        b_d    = lfsr_q[LfsrW-1:DW];
        lfsr_d = {lfsr_q[LfsrW-2:0], fb};
      end
    end
  end

  // Checking is independent of the FSM so stray out_valid is caught while idle
  always_comb begin
    pass_d     = pass_q;
    err_d      = err_q;
    mismatch_d = bad;
    done_d     = (state_q == StDone);
    if (accept) begin
      pass_d = '0;
      err_d  = '0;
    end else begin
      if (good && (pass_q != '1)) pass_d = pass_q + NUM_W'(1);
      if (bad && (err_q != '1))   err_d  = err_q + NUM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      num_ops_q   <= '0;
      gap_en_q    <= 1'b0;
      op_idx_q    <= '0;
      gap_skip_q  <= 1'b0;
      drain_cnt_q <= '0;
      lfsr_q      <= SeedInit;
      a_q         <= '0;
      b_q         <= '0;
      vld_q       <= 1'b0;
      pass_q      <= '0;
      err_q       <= '0;
      mismatch_q  <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_sum_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      num_ops_q   <= num_ops_d;
      gap_en_q    <= gap_en_d;
      op_idx_q    <= op_idx_d;
      gap_skip_q  <= gap_skip_d;
      drain_cnt_q <= drain_cnt_d;
      lfsr_q      <= lfsr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      vld_q       <= vld_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      mismatch_q  <= mismatch_d;
      done_q      <= done_d;
      dl_vld_q[0] <= vld_q;
      dl_sum_q[0] <= sum_in;
      for (int i = 1; i < LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_sum_q[i] <= dl_sum_q[i-1];
      end
    end
  end

  assign data_in0 = a_q;
  assign data_in1 = b_q;
  assign in_valid = vld_q;
  assign busy     = (state_q == StSend) || (state_q == StDrain);
  assign done     = done_q;
  assign mismatch = mismatch_q;
  assign pass_cnt = pass_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_adder_stim_gen.sv
// Directed bench: a one-cycle adder sits behind the generator, with hooks to corrupt
// its sum or force out_valid.
`timescale 1ns/1ps
module tb_adder_stim_gen;
  localparam int unsigned DW    = 9;
  localparam int unsigned NUM_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             gap_en = 1'b0;
  logic [NUM_W-1:0] num_ops = '0;
  logic [DW-1:0]    data_in0, data_in1;
  logic             in_valid, out_valid, busy, done, mismatch;
  logic [DW:0]      data_out;
  logic [NUM_W-1:0] pass_cnt, err_cnt;

  logic             force_bad = 1'b0;
  logic             force_ov = 1'b0;
  logic             add_vld_q;
  logic [DW:0]      add_sum_q;

  adder_stim_gen #(.DW(DW), .NUM_W(NUM_W), .LAT(1), .SEED(18'h1A5A5)) dut (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .gap_en(gap_en),
    .data_in0(data_in0), .data_in1(data_in1), .in_valid(in_valid),
    .data_out(data_out), .out_valid(out_valid), .busy(busy), .done(done),
    .mismatch(mismatch), .pass_cnt(pass_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      add_vld_q <= 1'b0;
      add_sum_q <= '0;
    end else begin
      add_vld_q <= in_valid;
      add_sum_q <= {1'b0, data_in0} + {1'b0, data_in1};
    end
  end
  assign data_out  = force_bad ? 10'h3FF : add_sum_q;
  assign out_valid = force_ov | add_vld_q;

  int checks = 0;
  int errors = 0;
  int zero_viol = 0;
  int op_n;
  logic [15:0]   iv_tr, dn_tr, bz_tr, mm_tr;
  logic [DW-1:0] op_a [16];
  logic [DW-1:0] op_b [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Trace bit k holds the value k+1 cycles after start was presented
  task automatic capture(input int n);
    iv_tr = '0; dn_tr = '0; bz_tr = '0; mm_tr = '0; op_n = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0;
      iv_tr[k] = in_valid; dn_tr[k] = done; bz_tr[k] = busy; mm_tr[k] = mismatch;
      if (in_valid) begin
        if (op_n < 16) begin
          op_a[op_n] = data_in0;
          op_b[op_n] = data_in1;
        end
        op_n++;
      end else if (data_in0 != '0 || data_in1 != '0) begin
        zero_viol++;
      end
    end
  endtask

  task automatic go(input int ops, input logic gap);
    @(negedge clk);
    num_ops = NUM_W'(ops);
    gap_en  = gap;
    start   = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk({tag, "_in_valid"}, in_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mismatch"}, mismatch, 0);
    chk({tag, "_pass"}, pass_cnt, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_data"}, {data_in1, data_in0}, 0);
  endtask

  initial begin
    do_reset("rst0");

    // 4 back-to-back ops, LAT=1
    go(4, 1'b0);
    capture(10);
    chk("t1_in_valid", iv_tr, 16'h001E);
    chk("t1_busy", bz_tr, 16'h001F);
    chk("t1_done", dn_tr, 16'h0040);
    chk("t1_op0", {op_b[0], op_a[0]}, 18'h00000);
    chk("t1_op1", {op_b[1], op_a[1]}, 18'h3FFFF);
    chk("t1_op2_a", op_a[2], 9'h1A5);
    chk("t1_op2_b", op_b[2], 9'h0D2);
    chk("t1_op3_a", op_a[3], 9'h14B);
    chk("t1_op3_b", op_b[3], 9'h1A5);
    chk("t1_pass", pass_cnt, 4);
    chk("t1_err", err_cnt, 0);
    chk("t1_mm", mm_tr, 0);

    // Gapped issue
    go(3, 1'b1);
    capture(10);
    chk("t2_in_valid", iv_tr, 16'h002A);
    chk("t2_busy", bz_tr, 16'h003F);
    chk("t2_done", dn_tr, 16'h0080);
    chk("t2_pass", pass_cnt, 3);
    chk("t2_err", err_cnt, 0);

    // Corrupted sums
    force_bad = 1'b1;
    go(4, 1'b0);
    capture(10);
    force_bad = 1'b0;
    chk("t3_ops", op_n, 4);
    chk("t3_mm", mm_tr, 16'h0078);
    chk("t3_err", err_cnt, 4);
    chk("t3_pass", pass_cnt, 0);

    // Spurious out_valid while idle
    do_reset("rst1");
    force_ov = 1'b1;
    repeat (5) @(negedge clk);
    force_ov = 1'b0;
    chk("t4_err", err_cnt, 5);
    chk("t4_pass", pass_cnt, 0);

    // Zero-length run also clears counters
    go(0, 1'b0);
    capture(4);
    chk("t5_in_valid", iv_tr, 0);
    chk("t5_busy", bz_tr, 0);
    chk("t5_done", dn_tr, 16'h0002);
    chk("t5_err", err_cnt, 0);

    // Reset in the third SEND cycle
    go(10, 1'b0);
    capture(3);
    chk("t6_pre_iv", iv_tr, 16'h0006);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_in_valid", in_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pass", pass_cnt, 0);
    chk("t6_err", err_cnt, 0);
    chk("t6_done_now", done, 0);
    capture(6);
    chk("t6_done_after", dn_tr, 0);
    chk("t6_iv_after", iv_tr, 0);

    // Restart: fixed ops first and LFSR back at seed
    go(3, 1'b0);
    capture(10);
    chk("t6b_in_valid", iv_tr, 16'h000E);
    chk("t6b_done", dn_tr, 16'h0020);
    chk("t6b_op0", {op_b[0], op_a[0]}, 18'h00000);
    chk("t6b_op2_a", op_a[2], 9'h1A5);
    chk("t6b_op2_b", op_b[2], 9'h0D2);
    chk("t6b_pass", pass_cnt, 3);
    chk("t6b_err", err_cnt, 0);

    chk("idle_data_zero", zero_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
